pampy_ctrl_fsm: RTL and testbench
=================================

PAMPY_CTRL_FSM -- requirements
Module: pampy_ctrl_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning opcode/argument width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, meaning pc and stack-pointer width.
REQ-003 SHALL have parameter STACK_DEPTH, default 256, meaning max stack entries (at most 2^ADDR_WIDTH).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: general_clk  in  1  clock; general_reset  in  1  async active-low reset.
REQ-005 SHALL have ports: start in 1 begin run; busy out 1; halted out 1; err out 1 sticky error.
REQ-006 SHALL have ports: imem_req out 1; imem_addr out ADDR_WIDTH; imem_ack in 1; imem_data in DATA_WIDTH.
REQ-007 SHALL have ports: reg1_load out 1 load regJump; reg2_sel out 2 (0 regArg, 1 tos, 2 pc); reg2_load out 1; arg out DATA_WIDTH.
REQ-008 SHALL have ports: ula_op out 4; ula_valid out 1; ula_zero in 1; stack_push out 1; stack_pop out 1; tos out ADDR_WIDTH; pc out ADDR_WIDTH.

Function
REQ-009 SHALL implement states IDLE, FETCH_OP, FETCH_ARG, DECODE, EXEC, HALT, ERROR.
REQ-010 SHALL go IDLE->FETCH_OP on start=1, with pc=0 and tos=0.
REQ-011 In FETCH_OP/FETCH_ARG, SHALL hold imem_req=1 and imem_addr=pc until imem_ack=1. On that edge it SHALL capture imem_data, increment pc and drop imem_req in the next cycle.
REQ-012 SHALL go to FETCH_ARG when opcode>=90 (HAVE_ARGUMENT), else to DECODE. After FETCH_ARG it SHALL go to DECODE.
REQ-013 DECODE SHALL take one cycle. EXEC SHALL take one cycle, then return to FETCH_OP. Non-jump instruction latency SHALL be 2 cycles plus fetch cycles.
REQ-014 NOP (0x09): no side effects.
REQ-015 POP_TOP (0x01): stack_pop=1, tos-1.
REQ-016 BINARY_ADD (0x17) and BINARY_SUBTRACT (0x18): ula_valid=1 with ula_op 1 or 2 respectively, stack_pop=1, tos-1.
REQ-017 LOAD_CONST (0x64): reg2_sel=0, reg2_load=1, stack_push=1, tos+1.
REQ-018 JUMP_ABSOLUTE (0x71): reg1_load=1 and pc<=zero-extended arg.
REQ-019 POP_JUMP_IF_FALSE (0x72): stack_pop=1 and tos-1. When ula_zero=1, it SHALL also load pc<=arg and assert reg1_load; otherwise pc is unchanged.
REQ-020 RETURN_VALUE (0x53): go to HALT, assert halted=1. start in HALT SHALL restart as in REQ-010.
REQ-021 Any other opcode: go to ERROR with err=1. ERROR SHALL be left only by reset.
REQ-022 pc SHALL wrap from 2^ADDR_WIDTH-1 to 0 silently.
REQ-023 start SHALL be ignored outside IDLE/HALT.
REQ-024 busy SHALL be 1 in FETCH_OP, FETCH_ARG, DECODE and EXEC. All strobes SHALL be single-cycle and mutually consistent within EXEC only.

Reset
REQ-025 Reset assertion SHALL force IDLE immediately, including mid-handshake. imem_req SHALL go to 0 asynchronously.
REQ-026 Reset values: all outputs 0, pc=0, tos=0, arg=0, ula_op=0.

Configuration
REQ-027 With PAMPY_STACK_CHECK_EN defined: a push at tos==STACK_DEPTH, or a pop (including binary ops) at tos==0, SHALL go to ERROR with err=1 and SHALL suppress that instruction's strobes.
REQ-028 Without PAMPY_STACK_CHECK_EN: tos SHALL wrap modulo 2^ADDR_WIDTH with no error.

Structure
REQ-029 Opcode constants, the ula_op encoding, the reg2_sel encoding and the state enum SHALL live in shared package pampy_pkg.
REQ-030 Opcode-to-control mapping SHALL be a combinational sub-module, pampy_decoder.

Verification
REQ-031 Program 64 05, 64 03, 17, 53: four LOAD_CONST/ADD/RETURN steps -> two pushes, one ula_valid with op 1, tos=1, halted=1, pc=6.
REQ-032 imem_ack delayed 3 cycles on every fetch -> imem_req held with stable imem_addr, no extra pc increments.
REQ-033 71 0A at pc 0 -> reg1_load=1, next imem_addr=0x00A; 72 04 with ula_zero=1 -> pc=4, with ula_zero=0 -> pc=2.
REQ-034 Opcode 0xFF -> err=1, state ERROR persists through start pulses until general_reset=0.
REQ-035 POP_TOP at tos=0 -> err=1 with PAMPY_STACK_CHECK_EN, tos=0xFFF and no err without it.
REQ-036 general_reset=0 asserted while imem_req=1 -> imem_req=0 same cycle, all outputs 0, and IDLE after release.

Source files
------------

// File: rtl/pampy_pkg.sv
// Shared definitions for the pampy bytecode controller: FSM states,
// opcode constants, ALU (ula) operation and reg2 source encodings, and the
// per-opcode control word produced by pampy_decoder.
package pampy_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_FETCH_ARG = 3'd2,
        ST_DECODE    = 3'd3,
        ST_EXEC      = 3'd4,
        ST_HALT      = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    // Opcodes (CPython-style bytecode subset)
    localparam logic [7:0] OP_POP_TOP           = 8'h01;
    localparam logic [7:0] OP_NOP               = 8'h09;
    localparam logic [7:0] OP_BINARY_ADD        = 8'h17;
    localparam logic [7:0] OP_BINARY_SUBTRACT   = 8'h18;
    localparam logic [7:0] OP_RETURN_VALUE      = 8'h53;
    localparam logic [7:0] OP_LOAD_CONST        = 8'h64;
    localparam logic [7:0] OP_JUMP_ABSOLUTE     = 8'h71;
    localparam logic [7:0] OP_POP_JUMP_IF_FALSE = 8'h72;

    // Opcodes at or above this value carry a one-byte argument
    localparam logic [7:0] OP_HAVE_ARGUMENT     = 8'd90;

    // ALU operation selector
    typedef enum logic [3:0] {
        ULA_NONE = 4'd0,
        ULA_ADD  = 4'd1,
        ULA_SUB  = 4'd2
    } ula_op_t;

    // reg2 load source selector
    typedef enum logic [1:0] {
        REG2_ARG = 2'd0,
        REG2_TOS = 2'd1,
        REG2_PC  = 2'd2
    } reg2_sel_t;

    // Control word for one decoded instruction
    typedef struct packed {
        logic      valid;      // opcode is recognised
        logic      halt;       // RETURN_VALUE
        logic      push;       // stack push, tos+1
        logic      pop;        // stack pop, tos-1
        logic      ula_valid;  // ALU operation requested
        ula_op_t   ula_op;
        logic      reg2_load;
        reg2_sel_t reg2_sel;
        logic      jump;       // unconditional pc <= arg
        logic      cond_jump;  // pc <= arg when ula_zero
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/pampy_decoder.sv
// Combinational opcode-to-control mapping for pampy_ctrl_fsm.
// Unknown opcodes leave ctrl.valid low so the controller can trap them.
import pampy_pkg::*;

module pampy_decoder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] opcode,
    output ctrl_t                 ctrl
);

    // Translate the captured opcode into a control word
    always_comb begin
        ctrl = CTRL_NONE;
        case (opcode)
            DATA_WIDTH'(OP_NOP): begin
                ctrl.valid = 1'b1;
            end
            DATA_WIDTH'(OP_POP_TOP): begin
                ctrl.valid = 1'b1;
                ctrl.pop   = 1'b1;
            end
            DATA_WIDTH'(OP_BINARY_ADD): begin
                ctrl.valid     = 1'b1;
                ctrl.pop       = 1'b1;
                ctrl.ula_valid = 1'b1;
                ctrl.ula_op    = ULA_ADD;
            end
            DATA_WIDTH'(OP_BINARY_SUBTRACT): begin
                ctrl.valid     = 1'b1;
                ctrl.pop       = 1'b1;
                ctrl.ula_valid = 1'b1;
                ctrl.ula_op    = ULA_SUB;
            end
            DATA_WIDTH'(OP_LOAD_CONST): begin
                ctrl.valid     = 1'b1;
                ctrl.push      = 1'b1;
                ctrl.reg2_load = 1'b1;
                ctrl.reg2_sel  = REG2_ARG;
            end
            DATA_WIDTH'(OP_JUMP_ABSOLUTE): begin
                ctrl.valid = 1'b1;
                ctrl.jump  = 1'b1;
            end
            DATA_WIDTH'(OP_POP_JUMP_IF_FALSE): begin
                ctrl.valid     = 1'b1;
                ctrl.pop       = 1'b1;
                ctrl.cond_jump = 1'b1;
            end
            DATA_WIDTH'(OP_RETURN_VALUE): begin
                ctrl.valid = 1'b1;
                ctrl.halt  = 1'b1;
            end
            default: begin
                ctrl = CTRL_NONE;
            end
        endcase
    end

endmodule

// File: rtl/pampy_ctrl_fsm.sv
// pampy_ctrl_fsm: fetch/decode/execute controller for a small stack-based
// bytecode machine. Fetches an opcode (plus an argument byte for opcodes
// >= HAVE_ARGUMENT) over a req/ack instruction port, then issues one cycle
// of strobes in EXEC.
// Optional feature: define PAMPY_STACK_CHECK_EN to trap stack overflow
// (push at tos == STACK_DEPTH) and underflow (pop at tos == 0) into ERROR.
// Without it tos wraps modulo 2^ADDR_WIDTH.
import pampy_pkg::*;

module pampy_ctrl_fsm #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int STACK_DEPTH = 256
) (
    input  logic                  general_clk,
    input  logic                  general_reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  halted,
    output logic                  err,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic                  reg1_load,
    output logic [1:0]            reg2_sel,
    output logic                  reg2_load,
    output logic [DATA_WIDTH-1:0] arg,
    output logic [3:0]            ula_op,
    output logic                  ula_valid,
    input  logic                  ula_zero,
    output logic                  stack_push,
    output logic                  stack_pop,
    output logic [ADDR_WIDTH-1:0] tos,
    output logic [ADDR_WIDTH-1:0] pc
);

`ifdef PAMPY_STACK_CHECK_EN
    localparam logic STACK_CHECK = 1'b1;
`else
    localparam logic STACK_CHECK = 1'b0;
`endif

    // One extra bit so a depth of exactly 2^ADDR_WIDTH is representable
    localparam logic [ADDR_WIDTH:0]   STACK_LIMIT = (ADDR_WIDTH + 1)'(STACK_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO   = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] HAVE_ARG    = DATA_WIDTH'(OP_HAVE_ARGUMENT);

    state_t                state_r;
    logic [DATA_WIDTH-1:0] opcode_r;
    ctrl_t                 dec_ctrl_s;
    logic                  push_ovf_s;
    logic                  pop_unf_s;
    logic                  stack_fault_s;
    logic                  take_jump_s;

    pampy_decoder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decoder (
        .opcode (opcode_r),
        .ctrl   (dec_ctrl_s)
    );

    // Stack bound checks and jump qualification for the decoded instruction
    always_comb begin
        push_ovf_s    = STACK_CHECK & dec_ctrl_s.push & ({1'b0, tos} == STACK_LIMIT);
        pop_unf_s     = STACK_CHECK & dec_ctrl_s.pop & (tos == ADDR_ZERO);
        stack_fault_s = push_ovf_s | pop_unf_s;
        take_jump_s   = dec_ctrl_s.jump | (dec_ctrl_s.cond_jump & ula_zero);
    end

    // Controller FSM with registered outputs; strobes default low every cycle
    always_ff @(posedge general_clk or negedge general_reset) begin
        if (!general_reset) begin
            state_r    <= ST_IDLE;
            opcode_r   <= {DATA_WIDTH{1'b0}};
            busy       <= 1'b0;
            halted     <= 1'b0;
            err        <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= ADDR_ZERO;
            reg1_load  <= 1'b0;
            reg2_sel   <= REG2_ARG;
            reg2_load  <= 1'b0;
            arg        <= {DATA_WIDTH{1'b0}};
            ula_op     <= ULA_NONE;
            ula_valid  <= 1'b0;
            stack_push <= 1'b0;
            stack_pop  <= 1'b0;
            tos        <= ADDR_ZERO;
            pc         <= ADDR_ZERO;
        end else begin
            reg1_load  <= 1'b0;
            reg2_sel   <= REG2_ARG;
            reg2_load  <= 1'b0;
            ula_op     <= ULA_NONE;
            ula_valid  <= 1'b0;
            stack_push <= 1'b0;
            stack_pop  <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_FETCH_OP;
                        pc      <= ADDR_ZERO;
                        tos     <= ADDR_ZERO;
                        busy    <= 1'b1;
                    end
                end

                ST_FETCH_OP: begin
                    if (!imem_req) begin
                        // Open the request; address held until the ack
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end else if (imem_ack) begin
                        opcode_r <= imem_data;
                        pc       <= pc + ADDR_ONE;
                        imem_req <= 1'b0;
                        if (imem_data >= HAVE_ARG) begin
                            state_r <= ST_FETCH_ARG;
                        end else begin
                            state_r <= ST_DECODE;
                        end
                    end
                end

                ST_FETCH_ARG: begin
                    if (!imem_req) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end else if (imem_ack) begin
                        arg      <= imem_data;
                        pc       <= pc + ADDR_ONE;
                        imem_req <= 1'b0;
                        state_r  <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    if (!dec_ctrl_s.valid || stack_fault_s) begin
                        // Unknown opcode or stack bound violation: no strobes
                        state_r <= ST_ERROR;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                    end else if (dec_ctrl_s.halt) begin
                        state_r <= ST_HALT;
                        halted  <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        // Strobes become visible for exactly the EXEC cycle
                        state_r    <= ST_EXEC;
                        stack_push <= dec_ctrl_s.push;
                        stack_pop  <= dec_ctrl_s.pop;
                        ula_valid  <= dec_ctrl_s.ula_valid;
                        ula_op     <= dec_ctrl_s.ula_op;
                        reg2_load  <= dec_ctrl_s.reg2_load;
                        reg2_sel   <= dec_ctrl_s.reg2_sel;
                        reg1_load  <= take_jump_s;
                        if (dec_ctrl_s.push) begin
                            tos <= tos + ADDR_ONE;
                        end else if (dec_ctrl_s.pop) begin
                            tos <= tos - ADDR_ONE;
                        end
                        if (take_jump_s) begin
                            pc <= ADDR_WIDTH'(arg);
                        end
                    end
                end

                ST_EXEC: begin
                    state_r <= ST_FETCH_OP;
                end

                ST_HALT: begin
                    if (start) begin
                        state_r <= ST_FETCH_OP;
                        pc      <= ADDR_ZERO;
                        tos     <= ADDR_ZERO;
                        halted  <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                ST_ERROR: begin
                    // Sticky until reset
                    err  <= 1'b1;
                    busy <= 1'b0;
                end

                default: begin
                    state_r  <= ST_ERROR;
                    err      <= 1'b1;
                    busy     <= 1'b0;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pampy_ctrl_fsm.sv
// Directed bench for pampy_ctrl_fsm: table of small programs with expected
// end state and strobe counts, plus hand sequences for restart, sticky error
// and reset during an open instruction fetch.
module tb_pampy_ctrl_fsm;

    localparam int NV = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, halted, err;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [7:0]  imem_data = 8'h00;
    logic        reg1_load;
    logic [1:0]  reg2_sel;
    logic        reg2_load;
    logic [7:0]  arg;
    logic [3:0]  ula_op;
    logic        ula_valid;
    logic        ula_zero = 1'b0;
    logic        stack_push, stack_pop;
    logic [11:0] tos, pc;

    pampy_ctrl_fsm #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (12),
        .STACK_DEPTH (256)
    ) dut (
        .general_clk   (clk),
        .general_reset (rst_n),
        .start         (start),
        .busy          (busy),
        .halted        (halted),
        .err           (err),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .reg1_load     (reg1_load),
        .reg2_sel      (reg2_sel),
        .reg2_load     (reg2_load),
        .arg           (arg),
        .ula_op        (ula_op),
        .ula_valid     (ula_valid),
        .ula_zero      (ula_zero),
        .stack_push    (stack_push),
        .stack_pop     (stack_pop),
        .tos           (tos),
        .pc            (pc)
    );

    always #5 clk = ~clk;

    // Instruction memory and its ack responder
    logic [7:0] mem [4096];
    int         ack_delay = 0;
    int         wait_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n || !imem_req) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (!imem_ack) begin
            if (wait_cnt >= ack_delay) begin
                imem_ack  = 1'b1;
                imem_data = mem[imem_addr];
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end
    end

    // Output monitor: cumulative strobe counts and protocol violations
    int          m_push = 0, m_pop = 0, m_ula = 0, m_jump = 0, m_r2 = 0;
    int          m_addr_bad = 0, m_dbl_bad = 0;
    logic [3:0]  m_ulaop = 4'd0;
    logic [11:0] m_jaddr = 12'd0;
    logic        m_jflag = 1'b0;
    logic        p_req = 1'b0, p_push = 1'b0, p_pop = 1'b0, p_ula = 1'b0, p_j = 1'b0;
    logic [11:0] p_addr = 12'd0;

    always @(negedge clk) begin
        if (stack_push) m_push = m_push + 1;
        if (stack_pop)  m_pop  = m_pop + 1;
        if (reg2_load)  m_r2   = m_r2 + 1;
        if (ula_valid) begin
            m_ula   = m_ula + 1;
            m_ulaop = ula_op;
        end
        if ((stack_push && p_push) || (stack_pop && p_pop) ||
            (ula_valid && p_ula) || (reg1_load && p_j))
            m_dbl_bad = m_dbl_bad + 1;
        if (rst_n && imem_req && p_req && (imem_addr != p_addr))
            m_addr_bad = m_addr_bad + 1;
        if (reg1_load) begin
            m_jump  = m_jump + 1;
            m_jflag = 1'b1;
        end else if (m_jflag && imem_req) begin
            m_jaddr = imem_addr;
            m_jflag = 1'b0;
        end
        p_req  = imem_req;
        p_addr = imem_addr;
        p_push = stack_push;
        p_pop  = stack_pop;
        p_ula  = ula_valid;
        p_j    = reg1_load;
    end

    typedef struct {
        string       name;
        int          delay;
        logic        zero;
        logic [11:0] exp_pc;
        logic [11:0] exp_tos;
        logic        exp_halted;
        logic        exp_err;
        int          exp_push;
        int          exp_pop;
        int          exp_ula;
        logic [3:0]  exp_ulaop;
        int          exp_jump;
        logic [11:0] exp_jaddr;
        int          exp_cycles;  // 0: latency not checked
    } vec_t;

    vec_t       vecs [NV];
    logic [7:0] prog [NV][16];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ld(input int v, input int a, input logic [7:0] b);
        prog[v][a] = b;
    endtask

    task automatic setv(input int v, input string nm, input int dly, input logic z,
                        input logic [11:0] epc, input logic [11:0] etos,
                        input logic eh, input logic ee, input int epush, input int epop,
                        input int eula, input logic [3:0] eop, input int ej,
                        input logic [11:0] eja, input int ecyc);
        vecs[v].name = nm;       vecs[v].delay = dly;     vecs[v].zero = z;
        vecs[v].exp_pc = epc;    vecs[v].exp_tos = etos;  vecs[v].exp_halted = eh;
        vecs[v].exp_err = ee;    vecs[v].exp_push = epush; vecs[v].exp_pop = epop;
        vecs[v].exp_ula = eula;  vecs[v].exp_ulaop = eop; vecs[v].exp_jump = ej;
        vecs[v].exp_jaddr = eja; vecs[v].exp_cycles = ecyc;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cyc);
        bit done;
        done = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 500; i++) begin
            if (!done) begin
                @(negedge clk);
                cyc = cyc + 1;
                if (halted || err) done = 1'b1;
            end
        end
        check({name, ".finished"}, 32'(done), 32'd1);
    endtask

    task automatic run_vec(input int v);
        int s_push, s_pop, s_ula, s_jump, s_r2, s_ab, s_db, cyc;
        apply_reset();
        for (int a = 0; a < 4096; a++) mem[a] = 8'hFF;
        for (int a = 0; a < 16; a++) mem[a] = prog[v][a];
        ack_delay = vecs[v].delay;
        ula_zero  = vecs[v].zero;
        s_push = m_push; s_pop = m_pop; s_ula = m_ula; s_jump = m_jump;
        s_r2 = m_r2; s_ab = m_addr_bad; s_db = m_dbl_bad;
        pulse_start();
        wait_done(vecs[v].name, cyc);
        @(negedge clk);
        check({vecs[v].name, ".pc"},     32'(pc),     32'(vecs[v].exp_pc));
        check({vecs[v].name, ".tos"},    32'(tos),    32'(vecs[v].exp_tos));
        check({vecs[v].name, ".halted"}, 32'(halted), 32'(vecs[v].exp_halted));
        check({vecs[v].name, ".err"},    32'(err),    32'(vecs[v].exp_err));
        check({vecs[v].name, ".busy"},   32'(busy),   32'd0);
        check({vecs[v].name, ".pushes"}, 32'(m_push - s_push), 32'(vecs[v].exp_push));
        check({vecs[v].name, ".reg2_loads"}, 32'(m_r2 - s_r2), 32'(vecs[v].exp_push));
        check({vecs[v].name, ".pops"},   32'(m_pop - s_pop),   32'(vecs[v].exp_pop));
        check({vecs[v].name, ".ula"},    32'(m_ula - s_ula),   32'(vecs[v].exp_ula));
        check({vecs[v].name, ".jumps"},  32'(m_jump - s_jump), 32'(vecs[v].exp_jump));
        check({vecs[v].name, ".addr_stable"}, 32'(m_addr_bad - s_ab), 32'd0);
        check({vecs[v].name, ".single_strobe"}, 32'(m_dbl_bad - s_db), 32'd0);
        if (vecs[v].exp_ula > 0)
            check({vecs[v].name, ".ula_op"}, 32'(m_ulaop), 32'(vecs[v].exp_ulaop));
        if (vecs[v].exp_jump > 0)
            check({vecs[v].name, ".jump_addr"}, 32'(m_jaddr), 32'(vecs[v].exp_jaddr));
        if (vecs[v].exp_cycles > 0)
            check({vecs[v].name, ".latency"}, 32'(cyc), 32'(vecs[v].exp_cycles));
    endtask

    initial begin
        int cyc;
        bit seen;

        for (int v = 0; v < NV; v++)
            for (int a = 0; a < 16; a++) prog[v][a] = 8'hFF;

        // LOAD_CONST 5, LOAD_CONST 3, BINARY_ADD, RETURN_VALUE
        ld(0, 0, 8'h64); ld(0, 1, 8'h05); ld(0, 2, 8'h64); ld(0, 3, 8'h03);
        ld(0, 4, 8'h17); ld(0, 5, 8'h53);
        setv(0, "add", 0, 1'b0, 12'd6, 12'd1, 1'b1, 1'b0, 2, 1, 1, 4'd1, 0, 12'd0, 19);
        // same program, every fetch acked 3 cycles late
        for (int a = 0; a < 16; a++) prog[1][a] = prog[0][a];
        setv(1, "add_slow", 3, 1'b0, 12'd6, 12'd1, 1'b1, 1'b0, 2, 1, 1, 4'd1, 0, 12'd0, 37);
        // JUMP_ABSOLUTE 0x0A, RETURN_VALUE at 0x0A
        ld(2, 0, 8'h71); ld(2, 1, 8'h0A); ld(2, 10, 8'h53);
        setv(2, "jabs", 0, 1'b0, 12'h00B, 12'd0, 1'b1, 1'b0, 0, 0, 0, 4'd0, 1, 12'h00A, 0);
        // LOAD_CONST, POP_JUMP_IF_FALSE 6 taken, RETURN_VALUE at 6
        ld(3, 0, 8'h64); ld(3, 1, 8'h00); ld(3, 2, 8'h72); ld(3, 3, 8'h06); ld(3, 6, 8'h53);
        setv(3, "pjif_taken", 0, 1'b1, 12'd7, 12'd0, 1'b1, 1'b0, 1, 1, 0, 4'd0, 1, 12'd6, 0);
        // POP_JUMP_IF_FALSE not taken, falls through to RETURN_VALUE
        ld(4, 0, 8'h64); ld(4, 1, 8'h00); ld(4, 2, 8'h72); ld(4, 3, 8'h06); ld(4, 4, 8'h53);
        setv(4, "pjif_fall", 0, 1'b0, 12'd5, 12'd0, 1'b1, 1'b0, 1, 1, 0, 4'd0, 0, 12'd0, 0);
        // 0xFF is >= 90 so its argument byte is fetched before the trap
        setv(5, "bad_opcode", 0, 1'b0, 12'd2, 12'd0, 1'b0, 1'b1, 0, 0, 0, 4'd0, 0, 12'd0, 0);
        // POP_TOP at empty stack
        ld(6, 0, 8'h01); ld(6, 1, 8'h53);
`ifdef PAMPY_STACK_CHECK_EN
        setv(6, "pop_empty", 0, 1'b0, 12'd1, 12'd0, 1'b0, 1'b1, 0, 0, 0, 4'd0, 0, 12'd0, 0);
`else
        setv(6, "pop_empty", 0, 1'b0, 12'd2, 12'hFFF, 1'b1, 1'b0, 0, 1, 0, 4'd0, 0, 12'd0, 0);
`endif
        // NOP, LOAD_CONST 7, BINARY_SUBTRACT, RETURN_VALUE
        ld(7, 0, 8'h09); ld(7, 1, 8'h64); ld(7, 2, 8'h07); ld(7, 3, 8'h18); ld(7, 4, 8'h53);
        setv(7, "sub", 1, 1'b0, 12'd5, 12'd0, 1'b1, 1'b0, 1, 1, 1, 4'd2, 0, 12'd0, 0);
        // taken conditional jump with slow memory
        for (int a = 0; a < 16; a++) prog[8][a] = prog[3][a];
        setv(8, "pjif_slow", 3, 1'b1, 12'd7, 12'd0, 1'b1, 1'b0, 1, 1, 0, 4'd0, 1, 12'd6, 0);

        // Reset state
        apply_reset();
        check("rst.busy",   32'(busy),   32'd0);
        check("rst.halted", 32'(halted), 32'd0);
        check("rst.err",    32'(err),    32'd0);
        check("rst.imem",   32'({imem_req, imem_addr}), 32'd0);
        check("rst.strobes", 32'({reg1_load, reg2_load, ula_valid, stack_push, stack_pop}), 32'd0);
        check("rst.sel_op_arg", 32'({reg2_sel, ula_op, arg}), 32'd0);
        check("rst.pc_tos", 32'({pc, tos}), 32'd0);

        for (int v = 0; v < NV; v++) run_vec(v);

        // Restart from HALT
        run_vec(0);
        pulse_start();
        check("restart.halted", 32'(halted), 32'd0);
        check("restart.busy",   32'(busy),   32'd1);
        check("restart.pc_tos", 32'({pc, tos}), 32'd0);
        wait_done("restart", cyc);
        check("restart.end_pc",  32'(pc),  32'd6);
        check("restart.end_tos", 32'(tos), 32'd1);
        check("restart.end_halted", 32'(halted), 32'd1);

        // ERROR is sticky across start pulses, cleared only by reset
        run_vec(5);
        for (int k = 0; k < 3; k++) begin
            pulse_start();
            @(negedge clk);
            check("sticky.err",  32'(err),  32'd1);
            check("sticky.busy", 32'({busy, imem_req}), 32'd0);
            check("sticky.pc",   32'(pc),   32'd2);
        end
        apply_reset();
        check("sticky.err_after_reset", 32'(err), 32'd0);

        // Reset while an instruction fetch is outstanding
        for (int a = 0; a < 16; a++) mem[a] = prog[0][a];
        ack_delay = 20;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!seen) begin
                @(negedge clk);
                if (imem_req) seen = 1'b1;
            end
        end
        check("midreset.req_seen", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset.req_drop", 32'(imem_req), 32'd0);
        check("midreset.outputs", 32'({busy, halted, err, reg1_load, reg2_load,
                                        ula_valid, stack_push, stack_pop}), 32'd0);
        check("midreset.pc_tos_addr", 32'({pc, tos, imem_addr}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midreset.idle", 32'({busy, imem_req, halted, err}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
